// File: rtl/msu_pkg.sv
// rtl/msu_pkg.sv - reduction grid types shared by the row-sum sequencer
package msu_pkg;

  // Reduction grid geometry
  localparam int TreeBits    = 8;
  localparam int RedGridRows = 16;
  localparam int RedSumBits  = 10;

  typedef logic [TreeBits-1:0]   red_term_t;
  typedef red_term_t             red_terms_t [RedGridRows];
  typedef logic [RedSumBits-1:0] red_sum_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } red_seq_state_e;

  // Unsigned widening of one grid term to the accumulator width
  function automatic red_sum_t zext_term(input red_term_t t);
    return red_sum_t'(t);
  endfunction

endpackage

// File: rtl/red_sum_chunk.sv
// rtl/red_sum_chunk.sv - adds one chunk of grid terms onto the running sum (carry with RED_SUM_SEQ_OVF_EN)
module red_sum_chunk
  import msu_pkg::*;
#(
  parameter int ChunkTerms = 4
) (
  input  red_sum_t  acc_i,
  input  red_term_t terms_i [ChunkTerms],
  output red_sum_t  sum_o
`ifdef RED_SUM_SEQ_OVF_EN
  ,
  output logic      carry_o
`endif
);

  // Extra headroom bits exist only when the carry is observed
`ifdef RED_SUM_SEQ_OVF_EN
  localparam int WideBits = RedSumBits + $clog2(ChunkTerms + 1);
`else
  localparam int WideBits = RedSumBits;
`endif

  logic [WideBits-1:0] wide;

  // Accumulate the chunk terms onto the incoming partial sum
  always_comb begin
    wide = WideBits'(acc_i);
    for (int i = 0; i < ChunkTerms; i++) begin
      wide = wide + WideBits'(zext_term(terms_i[i]));
    end
  end

  assign sum_o = wide[RedSumBits-1:0];

`ifdef RED_SUM_SEQ_OVF_EN
  assign carry_o = |wide[WideBits-1:RedSumBits];
`endif

endmodule

// File: rtl/red_sum_seq.sv
// rtl/red_sum_seq.sv - time-multiplexed reduction grid row sum; optional ovf_o via RED_SUM_SEQ_OVF_EN
module red_sum_seq
  import msu_pkg::*;
#(
  parameter int ChunkTerms = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  red_terms_t terms_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output red_sum_t   sum_o,
  output logic       busy_o
`ifdef RED_SUM_SEQ_OVF_EN
  ,
  output logic       ovf_o
`endif
);

  localparam int NumChunks = RedGridRows / ChunkTerms;
  localparam int CntBits   = $clog2(NumChunks) + 1;
  localparam int IdxBits   = $clog2(RedGridRows);

  if ((RedGridRows % ChunkTerms) != 0) begin : g_bad_chunk
    $error("red_sum_seq: ChunkTerms must divide RedGridRows");
  end

  red_seq_state_e     state_q, state_d;
  logic [CntBits-1:0] cnt_q;
  red_sum_t           acc_q;
  red_sum_t           sum_q;
  red_terms_t         buf_q;
  red_term_t          chunk_terms [ChunkTerms];
  red_sum_t           chunk_sum;
  logic [IdxBits-1:0] base_idx;
  logic               accept;
  logic               last_chunk;
`ifdef RED_SUM_SEQ_OVF_EN
  logic               chunk_carry;
  logic               ovf_q;
`endif

  assign accept     = in_ready_o & in_valid_i;
  assign last_chunk = (cnt_q == CntBits'(NumChunks - 1));

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = ACCUM;
      end
      ACCUM: begin
        busy_o = 1'b1;
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the chunk of buffered terms addressed by the chunk counter
  always_comb begin
    base_idx = IdxBits'(int'(cnt_q) * ChunkTerms);
    for (int i = 0; i < ChunkTerms; i++) begin
      chunk_terms[i] = buf_q[base_idx + IdxBits'(i)];
    end
  end

  red_sum_chunk #(
    .ChunkTerms(ChunkTerms)
  ) u_chunk (
    .acc_i   (acc_q),
    .terms_i (chunk_terms),
    .sum_o   (chunk_sum)
`ifdef RED_SUM_SEQ_OVF_EN
    ,
    .carry_o (chunk_carry)
`endif
  );

  // Term buffer captures only on an accepted batch; contents need no reset
  always_ff @(posedge clk_i) begin
    if (accept) buf_q <= terms_i;
  end

  // Accumulator, chunk counter and registered result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
`ifdef RED_SUM_SEQ_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q <= '0;
      acc_q <= '0;
`ifdef RED_SUM_SEQ_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (state_q == ACCUM) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= chunk_sum;
      if (last_chunk) sum_q <= chunk_sum;
`ifdef RED_SUM_SEQ_OVF_EN
      ovf_q <= ovf_q | chunk_carry;
`endif
    end
  end

  assign sum_o = sum_q;

`ifdef RED_SUM_SEQ_OVF_EN
  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_red_sum_seq.sv
// tb/tb_red_sum_seq.sv - directed bench for red_sum_seq (16 terms x 8b, 10b sum, 4 chunks); RED_SUM_SEQ_OVF_EN adds overflow cases
module tb_red_sum_seq;
  import msu_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       in_valid_i;
  logic       in_ready_o;
  red_terms_t terms;
  logic       out_valid_o;
  logic       out_ready_i;
  red_sum_t   sum_o;
  logic       busy_o;
`ifdef RED_SUM_SEQ_OVF_EN
  logic       ovf_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  red_sum_seq #(
    .ChunkTerms(4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .terms_i     (terms),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .busy_o      (busy_o)
`ifdef RED_SUM_SEQ_OVF_EN
    ,
    .ovf_o       (ovf_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_all(input int val);
    for (int i = 0; i < RedGridRows; i++) terms[i] = red_term_t'(val);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < RedGridRows; i++) terms[i] = red_term_t'(i);
  endtask

  // Called at ACCUM cycle 1; returns the cycle index at which out_valid_o is seen
  task automatic wait_valid(output int c);
    c = 1;
    while (out_valid_o !== 1'b1 && c < 40) begin
      step();
      c++;
    end
  endtask

  task automatic send_batch();
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
  endtask

  initial begin
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    set_all(0);
    step();
    step();
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_sum", sum_o, 0);
`ifdef RED_SUM_SEQ_OVF_EN
    check("rst_ovf", ovf_o, 0);
`endif
    rst_ni = 1'b1;
    step();

    // 1: all ones -> 16, valid at cycle 5, one cycle wide
    set_all(1);
    out_ready_i = 1'b1;
    check("t1_in_ready_idle", in_ready_o, 1);
    send_batch();
    check("t1_busy_accum", busy_o, 1);
    check("t1_in_ready_accum", in_ready_o, 0);
    wait_valid(cyc);
    check("t1_latency", cyc, 5);
    check("t1_sum", sum_o, 16);
    step();
    check("t1_valid_one_cycle", out_valid_o, 0);
    check("t1_sum_retained", sum_o, 16);
    check("t1_back_idle", in_ready_o, 1);
`ifdef RED_SUM_SEQ_OVF_EN
    check("t1_ovf", ovf_o, 0);
`endif

    // 2: ramp 0..15 -> 120
    set_ramp();
    send_batch();
    wait_valid(cyc);
    check("t2_latency", cyc, 5);
    check("t2_sum", sum_o, 120);
    step();

    // 3: stall in DONE for 10 cycles with in_valid_i pulses; all fives -> 80
    out_ready_i = 1'b0;
    set_all(5);
    send_batch();
    wait_valid(cyc);
    check("t3_sum", sum_o, 80);
    set_all(7);
    for (int i = 0; i < 10; i++) begin
      in_valid_i = (i % 2 == 0);
      step();
      check("t3_stall_valid", out_valid_o, 1);
      check("t3_stall_sum", sum_o, 80);
      check("t3_stall_in_ready", in_ready_o, 0);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    check("t3_release_valid", out_valid_o, 0);
    check("t3_release_idle", in_ready_o, 1);
    check("t3_no_capture", busy_o, 0);

    // 4: back-to-back A (all 2 -> 32) and B (all 3 -> 48) with in_valid_i held
    set_all(2);
    in_valid_i = 1'b1;
    step();
    set_all(3);
    wait_valid(cyc);
    check("t4a_latency", cyc, 5);
    check("t4a_sum", sum_o, 32);
    step();
    check("t4_idle_after_a", in_ready_o, 1);
    check("t4_valid_low", out_valid_o, 0);
    step();
    check("t4b_accepted", busy_o, 1);
    in_valid_i = 1'b0;
    wait_valid(cyc);
    check("t4b_latency", cyc, 5);
    check("t4b_sum", sum_o, 48);
    step();

    // 5: async reset at ACCUM cycle 1, then all fours -> 64
    set_all(9);
    send_batch();
    rst_ni = 1'b0;
    #1;
    check("t5_rst_in_ready", in_ready_o, 1);
    check("t5_rst_out_valid", out_valid_o, 0);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_sum", sum_o, 0);
    step();
    rst_ni = 1'b1;
    set_all(4);
    send_batch();
    wait_valid(cyc);
    check("t5_latency", cyc, 5);
    check("t5_sum", sum_o, 64);
    step();

`ifdef RED_SUM_SEQ_OVF_EN
    // 6: all 255 -> 4080 mod 1024 = 1008 with overflow; then zeros clear it
    set_all(255);
    send_batch();
    wait_valid(cyc);
    check("t6_sum_wrap", sum_o, 1008);
    check("t6_ovf_set", ovf_o, 1);
    step();
    check("t6_ovf_held", ovf_o, 1);
    set_all(0);
    send_batch();
    check("t6_ovf_clear_accept", ovf_o, 0);
    wait_valid(cyc);
    check("t6_zero_sum", sum_o, 0);
    check("t6_zero_ovf", ovf_o, 0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
